// File: rtl/ddr3_dma_write_arb.sv
// Round-robin arbiter sharing one DDR3 DMA write engine among NUM_REQ producers.
// Issues a single-cycle job request, steers the owner's data stream, returns done/err pulses.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; pick the next requester round-robin from ptr
// ISSUE  | one cycle, dma_write_req high with registered addr/len
// XFER   | owner's data and flow control routed to the engine
// DONE   | one cycle, req_done (and req_err for a rejected job) to owner
module ddr3_dma_write_arb #(
    parameter int NUM_REQ        = 4,
    parameter int DMA_ADDR_WIDTH = 27,
    parameter int DATA_WIDTH     = 512,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*DMA_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DMA_ADDR_WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [NUM_REQ-1:0]               req_err,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_din,
    input  logic [NUM_REQ-1:0]               req_din_en,
    input  logic [NUM_REQ-1:0]               req_din_eop,
    output logic [NUM_REQ-1:0]               req_din_rdy,
    output logic [NUM_REQ-1:0]               grant,
    output logic                             busy,
    output logic                             dma_write_req,
    output logic [DMA_ADDR_WIDTH-1:0]        dma_write_start_addr,
    output logic [DMA_ADDR_WIDTH-1:0]        dma_write_length,
    input  logic                             dma_write_done,
    output logic [DATA_WIDTH-1:0]            dma_din,
    output logic                             dma_din_en,
    output logic                             dma_din_eop,
    input  logic                             dma_din_rdy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic [IDX_W-1:0]           gidx_q, gidx_d;
    logic                       err_q, err_d;
    logic [NUM_REQ-1:0]         grant_q, grant_d;
    logic [DMA_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DMA_ADDR_WIDTH-1:0]  len_q, len_d;

    logic [DMA_ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
    logic [DMA_ADDR_WIDTH-1:0]  len_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]      din_arr  [NUM_REQ];

    logic                       win_vld;
    logic [IDX_W-1:0]           win_idx;
    logic [IDX_W-1:0]           cand;
    logic [NUM_REQ-1:0]         g_onehot;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
        assign len_arr[i]  = req_len[i*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
        assign din_arr[i]  = req_din[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        err_d   = err_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gidx_d = win_idx;
                    ptr_d  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    // The engine cannot run jobs shorter than two beats.
                    if (len_arr[win_idx] < DMA_ADDR_WIDTH'(2)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        grant_d = NUM_REQ'(1) << win_idx;
                        addr_d  = addr_arr[win_idx];
                        len_d   = len_arr[win_idx];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_XFER;
            S_XFER: begin
                if (dma_write_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            err_q   <= 1'b0;
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign g_onehot             = NUM_REQ'(1) << gidx_q;
    assign grant                = grant_q;
    assign busy                 = (state_q != S_IDLE);
    assign dma_write_req        = (state_q == S_ISSUE);
    assign dma_write_start_addr = addr_q;
    assign dma_write_length     = len_q;
    assign req_done             = (state_q == S_DONE) ? g_onehot : '0;
    assign req_err              = (state_q == S_DONE && err_q) ? g_onehot : '0;

    // Data path is a pure mux in XFER so it adds no pipeline latency.
    always_comb begin
        dma_din     = '0;
        dma_din_en  = 1'b0;
        dma_din_eop = 1'b0;
        req_din_rdy = '0;
        if (state_q == S_XFER) begin
            dma_din             = din_arr[gidx_q];
            dma_din_en          = req_din_en[gidx_q];
            dma_din_eop         = req_din_eop[gidx_q];
            req_din_rdy[gidx_q] = dma_din_rdy;
        end
    end

endmodule

// File: tb/tb_ddr3_dma_write_arb.sv
// Directed bench for ddr3_dma_write_arb: single job, fairness, reject, isolation, async reset.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_ddr3_dma_write_arb;

    localparam int NR = 4;
    localparam int AW = 27;
    localparam int DW = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*AW-1:0]  req_len;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic [NR*DW-1:0]  req_din;
    logic [NR-1:0]     req_din_en;
    logic [NR-1:0]     req_din_eop;
    logic [NR-1:0]     req_din_rdy;
    logic [NR-1:0]     grant;
    logic              busy;
    logic              dma_write_req;
    logic [AW-1:0]     dma_write_start_addr;
    logic [AW-1:0]     dma_write_length;
    logic              dma_write_done;
    logic [DW-1:0]     dma_din;
    logic              dma_din_en;
    logic              dma_din_eop;
    logic              dma_din_rdy;

    int vectors     = 0;
    int miscompares = 0;
    int wreq_cnt    = 0;

    ddr3_dma_write_arb #(
        .NUM_REQ(NR), .DMA_ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_addr(req_addr), .req_len(req_len),
        .req_done(req_done), .req_err(req_err),
        .req_din(req_din), .req_din_en(req_din_en), .req_din_eop(req_din_eop),
        .req_din_rdy(req_din_rdy), .grant(grant), .busy(busy),
        .dma_write_req(dma_write_req), .dma_write_start_addr(dma_write_start_addr),
        .dma_write_length(dma_write_length), .dma_write_done(dma_write_done),
        .dma_din(dma_din), .dma_din_en(dma_din_en), .dma_din_eop(dma_din_eop),
        .dma_din_rdy(dma_din_rdy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dma_write_req === 1'b1) wreq_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_job(input int i, input logic [AW-1:0] addr, input logic [AW-1:0] len);
        req_addr[i*AW +: AW] = addr;
        req_len[i*AW +: AW]  = len;
    endtask

    task automatic beat(input int i, input logic [31:0] w, input logic en, input logic eop);
        req_din[i*DW +: DW] = {16{w}};
        req_din_en[i]       = en;
        req_din_eop[i]      = eop;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0; req_din = '0;
        req_din_en = '0; req_din_eop = '0; dma_write_done = 1'b0; dma_din_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (dma_write_req !== 1'b0) begin miscompares++; $display("FAIL reset_wreq: got %b expected 0", dma_write_req); end
        vectors++; if ({req_done, req_err} !== 8'h00) begin miscompares++; $display("FAIL reset_done_err: got %b expected 00000000", {req_done, req_err}); end
        vectors++; if (req_din_rdy !== 4'b0000) begin miscompares++; $display("FAIL reset_rdy: got %b expected 0000", req_din_rdy); end
        vectors++; if ({dma_din_en, dma_din_eop} !== 2'b00 || dma_din !== '0) begin miscompares++; $display("FAIL reset_din: got en=%b eop=%b expected 0 0 and zero data", dma_din_en, dma_din_eop); end
        vectors++; if (dma_write_start_addr !== '0 || dma_write_length !== '0) begin miscompares++; $display("FAIL reset_addr_len: got %h/%h expected 0/0", dma_write_start_addr, dma_write_length); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int fwd = 0;
        int w0  = wreq_cnt;
        logic [DW-1:0] exp_d;
        set_job(1, 27'h100, 27'd32);
        req = 4'b0010; dma_din_rdy = 1'b1;
        @(negedge clk); #1;
        vectors++; if (dma_write_req !== 1'b1) begin miscompares++; $display("FAIL single_wreq: got %b expected 1", dma_write_req); end
        vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL single_grant: got %b expected 0010", grant); end
        vectors++; if (dma_write_start_addr !== 27'h100) begin miscompares++; $display("FAIL single_addr: got %h expected 100", dma_write_start_addr); end
        vectors++; if (dma_write_length !== 27'd32) begin miscompares++; $display("FAIL single_len: got %0d expected 32", dma_write_length); end
        @(negedge clk); #1;
        vectors++; if (dma_write_req !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_xfer_entry: got wreq=%b busy=%b expected 0 1", dma_write_req, busy); end
        for (int b = 0; b < 32; b++) begin
            beat(1, 32'h1000_0000 + 32'(b), 1'b1, b == 31);
            exp_d = {16{32'h1000_0000 + 32'(b)}};
            #1;
            if (dma_din_en === 1'b1 && dma_din_rdy === 1'b1) fwd++;
            vectors++; if (dma_din !== exp_d) begin miscompares++; $display("FAIL single_data beat %0d: got %h expected %h", b, dma_din[31:0], exp_d[31:0]); end
            vectors++; if (dma_din_eop !== (b == 31)) begin miscompares++; $display("FAIL single_eop beat %0d: got %b expected %b", b, dma_din_eop, b == 31); end
            @(negedge clk); #1;
        end
        beat(1, 32'h0, 1'b0, 1'b0);
        dma_write_done = 1'b1;
        @(negedge clk); #1;
        dma_write_done = 1'b0;
        vectors++; if (fwd !== 32) begin miscompares++; $display("FAIL single_beats: got %0d expected 32", fwd); end
        vectors++; if (req_done !== 4'b0010) begin miscompares++; $display("FAIL single_done: got %b expected 0010", req_done); end
        vectors++; if (req_err !== 4'b0000) begin miscompares++; $display("FAIL single_err: got %b expected 0000", req_err); end
        req = '0;
        @(negedge clk); #1;
        vectors++; if (busy !== 1'b0 || req_done !== 4'b0000) begin miscompares++; $display("FAIL single_idle: got busy=%b done=%b expected 0 0000", busy, req_done); end
        vectors++; if (wreq_cnt - w0 !== 1) begin miscompares++; $display("FAIL single_wreq_count: got %0d expected 1", wreq_cnt - w0); end
    endtask

    task automatic test_fairness;
        int g;
        logic [DW-1:0] exp_d;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) set_job(i, AW'(32'h1000 * (i + 1)), 27'd4);
        req = 4'b1111; dma_din_rdy = 1'b1;
        for (int j = 0; j < 5; j++) begin
            g = j % NR;
            @(negedge clk); #1;
            vectors++; if (grant !== NR'(1 << g)) begin miscompares++; $display("FAIL fair_grant job %0d: got %b expected %b", j, grant, NR'(1 << g)); end
            vectors++; if (dma_write_start_addr !== AW'(32'h1000 * (g + 1))) begin miscompares++; $display("FAIL fair_addr job %0d: got %h expected %h", j, dma_write_start_addr, 32'h1000 * (g + 1)); end
            @(negedge clk); #1;
            for (int b = 0; b < 4; b++) begin
                beat(g, 32'h2000_0000 + 32'(j * 16 + b), 1'b1, b == 3);
                exp_d = {16{32'h2000_0000 + 32'(j * 16 + b)}};
                #1;
                vectors++; if (dma_din !== exp_d || dma_din_en !== 1'b1) begin miscompares++; $display("FAIL fair_data job %0d beat %0d: got %h en=%b expected %h en=1", j, b, dma_din[31:0], dma_din_en, exp_d[31:0]); end
                @(negedge clk); #1;
            end
            beat(g, 32'h0, 1'b0, 1'b0);
            dma_write_done = 1'b1;
            @(negedge clk); #1;
            dma_write_done = 1'b0;
            vectors++; if (req_done !== NR'(1 << g)) begin miscompares++; $display("FAIL fair_done job %0d: got %b expected %b", j, req_done, NR'(1 << g)); end
            @(negedge clk); #1;
        end
        req = '0;
    endtask

    task automatic test_reject;
        int w0 = wreq_cnt;
        for (int t = 0; t < 2; t++) begin
            set_job(2, 27'h300, (t == 0) ? 27'd1 : 27'd0);
            req = 4'b0100;
            @(negedge clk); #1;
            vectors++; if (req_done !== 4'b0100) begin miscompares++; $display("FAIL reject_done len %0d: got %b expected 0100", 1 - t, req_done); end
            vectors++; if (req_err !== 4'b0100) begin miscompares++; $display("FAIL reject_err len %0d: got %b expected 0100", 1 - t, req_err); end
            vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reject_grant len %0d: got %b expected 0000", 1 - t, grant); end
            req = '0;
            @(negedge clk); #1;
            vectors++; if (busy !== 1'b0 || req_done !== 4'b0000) begin miscompares++; $display("FAIL reject_idle len %0d: got busy=%b done=%b expected 0 0000", 1 - t, busy, req_done); end
        end
        vectors++; if (wreq_cnt - w0 !== 0) begin miscompares++; $display("FAIL reject_no_wreq: got %0d expected 0", wreq_cnt - w0); end
        set_job(1, 27'h1100, 27'd4);
        set_job(3, 27'h3300, 27'd4);
        req = 4'b1010;
        @(negedge clk); #1;
        vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL reject_ptr: got %b expected 1000", grant); end
        req = '0;
        @(negedge clk); #1;
        dma_write_done = 1'b1;
        @(negedge clk); #1;
        dma_write_done = 1'b0;
        vectors++; if (req_done !== 4'b1000) begin miscompares++; $display("FAIL reject_ptr_done: got %b expected 1000", req_done); end
        @(negedge clk); #1;
    endtask

    task automatic test_isolation;
        logic rdy;
        logic en0;
        logic [DW-1:0] exp_d;
        set_job(0, 27'h40, 27'd8);
        req = 4'b0001;
        @(negedge clk); #1;
        vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL iso_grant: got %b expected 0001", grant); end
        @(negedge clk); #1;
        beat(3, 32'hDEAD_BEEF, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            rdy = (k % 2) == 1;
            en0 = (k != 2);
            dma_din_rdy = rdy;
            beat(0, 32'h4000_0000 + 32'(k), en0, 1'b0);
            exp_d = {16{32'h4000_0000 + 32'(k)}};
            #1;
            vectors++; if (req_din_rdy !== {3'b000, rdy}) begin miscompares++; $display("FAIL iso_rdy step %0d: got %b expected %b", k, req_din_rdy, {3'b000, rdy}); end
            vectors++; if (dma_din_en !== en0 || dma_din_eop !== 1'b0) begin miscompares++; $display("FAIL iso_en step %0d: got en=%b eop=%b expected %b 0", k, dma_din_en, dma_din_eop, en0); end
            vectors++; if (dma_din !== exp_d) begin miscompares++; $display("FAIL iso_data step %0d: got %h expected %h", k, dma_din[31:0], exp_d[31:0]); end
            @(negedge clk); #1;
        end
        req_din_en = '0; req_din_eop = '0; dma_din_rdy = 1'b1;
        dma_write_done = 1'b1;
        @(negedge clk); #1;
        dma_write_done = 1'b0;
        vectors++; if (req_done !== 4'b0001) begin miscompares++; $display("FAIL iso_done: got %b expected 0001", req_done); end
        req = '0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset_mid;
        set_job(2, 27'h500, 27'd4);
        req = 4'b0100;
        @(negedge clk); #1;
        @(negedge clk); #1;
        beat(2, 32'h5555_0000, 1'b1, 1'b0);
        dma_din_rdy = 1'b1;
        #1;
        vectors++; if (dma_din_en !== 1'b1 || grant !== 4'b0100) begin miscompares++; $display("FAIL midrst_pre: got en=%b grant=%b expected 1 0100", dma_din_en, grant); end
        rst_n = 1'b0;
        #1;
        vectors++; if (grant !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_grant_busy: got %b %b expected 0000 0", grant, busy); end
        vectors++; if (dma_din_en !== 1'b0 || dma_din !== '0 || req_din_rdy !== 4'b0000) begin miscompares++; $display("FAIL midrst_datapath: got en=%b rdy=%b expected 0 0000", dma_din_en, req_din_rdy); end
        vectors++; if (req_done !== 4'b0000 || dma_write_req !== 1'b0 || dma_write_start_addr !== '0) begin miscompares++; $display("FAIL midrst_outputs: got done=%b wreq=%b addr=%h expected 0000 0 0", req_done, dma_write_req, dma_write_start_addr); end
        req_din_en = '0; req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (req_done !== 4'b0000) begin miscompares++; $display("FAIL midrst_no_done: got %b expected 0000", req_done); end
        for (int i = 0; i < NR; i++) set_job(i, AW'(32'h600 + i), 27'd4);
        req = 4'b1101;
        @(negedge clk); #1;
        vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL midrst_first_grant: got %b expected 0001", grant); end
        req = '0;
        @(negedge clk); #1;
        dma_write_done = 1'b1;
        @(negedge clk); #1;
        dma_write_done = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_reject();
        test_isolation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr3_dma_write_arb.md
# ddr3_dma_write_arb

Round-robin arbiter and sequencer that shares one DDR3 DMA write engine among `NUM_REQ` on-chip producers, for example layer output writers.
- Per requester, it accepts a write job of start address and length in 64 B beats.
- It issues the job to the engine as a single-cycle `write_req`.
- It steers the granted requester's data stream and flow control to the engine, then returns a completion pulse.
- It sits in the `clk` domain, between the compute pipeline and the DMA write engine.

## Interface
Parameters
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DMA_ADDR_WIDTH`, 27: beat address and length width.
- `DATA_WIDTH`, 512: data beat width.
- `IDX_W`, `$clog2(NUM_REQ)`: grant index width.

Ports
- `clk` in 1: single clock. All logic is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: per-requester job request. Held high until the matching `req_done`.
- `req_addr` in `NUM_REQ*DMA_ADDR_WIDTH`: start beat address. Requester i uses slice i. Stable while `req[i]` is high.
- `req_len` in `NUM_REQ*DMA_ADDR_WIDTH`: length in beats, slice i. Stable while `req[i]` is high.
- `req_done` out `NUM_REQ`: one-cycle completion pulse.
- `req_err` out `NUM_REQ`: one-cycle pulse, coincident with `req_done`, when a job is rejected.
- `req_din` in `NUM_REQ*DATA_WIDTH`: data, slice i.
- `req_din_en` in `NUM_REQ`: data valid.
- `req_din_eop` in `NUM_REQ`: last beat marker.
- `req_din_rdy` out `NUM_REQ`: flow control to each requester.
- `grant` out `NUM_REQ`: one-hot, registered. Marks the current owner.
- `busy` out 1: high in every state except IDLE.
- `dma_write_req` out 1: one-cycle job start pulse to the engine.
- `dma_write_start_addr` out `DMA_ADDR_WIDTH`: registered start address.
- `dma_write_length` out `DMA_ADDR_WIDTH`: registered length.
- `dma_write_done` in 1: engine completion pulse.
- `dma_din` out `DATA_WIDTH`: data to the engine.
- `dma_din_en` out 1: data valid to the engine.
- `dma_din_eop` out 1: last beat marker to the engine.
- `dma_din_rdy` in 1: engine flow control.

## Operation
- States: IDLE, ISSUE, XFER, DONE.
- Round-robin pointer `ptr` (`IDX_W` bits), reset 0.
  - In IDLE, the winner is the first index with `req` high, searching `ptr`, `ptr+1`, … modulo `NUM_REQ`.
  - After any grant or reject of index g, `ptr` becomes (g+1) mod `NUM_REQ`.
- IDLE, at least one `req` high, winner g:
  - If `req_len` slice g is less than 2, the job is rejected. The engine requires at least 2 beats.
  - Go to DONE with the error flag set. No `dma_write_req` is issued.
  - Otherwise, latch g, the address and the length; set `grant[g]`, `dma_write_req`=1; go to ISSUE.
- ISSUE, exactly one cycle: `dma_write_req`=1, then go to XFER.
- XFER:
  - `dma_din` = `req_din[g]`.
  - `dma_din_en` = `req_din_en[g]`.
  - `dma_din_eop` = `req_din_eop[g]`.
  - `req_din_rdy[g]` = `dma_din_rdy`.
  - All other `req_din_rdy` bits are 0. Their `din_en` inputs are ignored.
  - On `dma_write_done`, go to DONE.
- DONE, one cycle: `req_done[g]`=1, and `req_err[g]`=1 if the job was rejected. Clear `grant`, go to IDLE.
- Outside XFER, all `dma_din*` outputs are 0 and all `req_din_rdy` bits are 0.
- A `req` that drops before its grant is simply not served. A `req` that drops after grant is ignored: the job runs to `dma_write_done`.
- An asynchronous `rst_n` assertion mid-job returns the block to IDLE and clears `grant`, `ptr` and all outputs. Engine recovery is the engine's own reset.

## Timing
- Reset values: `req_done`, `req_err`, `grant`, `busy`, `dma_write_req`, the `dma_*` outputs and `req_din_rdy` are all 0. State is IDLE.
- Accepted job, `req` sampled high in IDLE at cycle 0:
  - Cycle 1: ISSUE, with `grant` and `dma_write_req` high.
  - Cycle 2: XFER.
- The data path mux and `req_din_rdy` are combinational in XFER. They add no latency.
- `dma_write_done` at cycle k in XFER gives `req_done` at k+1. The block returns to IDLE at k+2.
- Back-to-back: the next job's `dma_write_req` is at the earliest k+3.
- Rejected job: `req_done` and `req_err` at cycle 1, back in IDLE at cycle 2.
- The requester deasserts `req` at the edge ending its `req_done` cycle. The arbiter samples `req` again only in IDLE, one cycle after DONE.
- `dma_write_start_addr` and `dma_write_length` are held from ISSUE until the next grant.

## Test plan
- Single job: reset, then `req[1]` with addr 0x100 and len 32, streaming 32 beats with `dma_din_rdy`=1.
  - Required: `dma_write_req` high 1 cycle, with addr 0x100 and length 32.
  - Required: exactly 32 beats forwarded.
  - Required: `req_done[1]` one cycle after `dma_write_done`, and `req_err`=0.
- Fairness: `req` = 4'b1111 held, with each job `dma_write_done` sent after 4 beats. Required grant order is 0,1,2,3,0. `ptr` advances as specified.
- Reject: `req[2]` with len 1, and separately with len 0. Required: `req_done[2]` and `req_err[2]` at cycle 1, no `dma_write_req`, and `ptr` becomes 3.
- Isolation: during requester 0's XFER, requester 3 drives `din_en`=1. Required: `req_din_rdy[3]`=0 and no beats from requester 3 on `dma_din`. Toggle `dma_din_rdy`; `req_din_rdy[0]` must track it exactly.
- Reset mid-XFER: assert `rst_n`=0 asynchronously. Required: all outputs 0 immediately, no `req_done`, and after release the first grant goes to index 0.
